// File: rtl/lsu_mem_access_if.sv
// Data-memory bus between the LSU (master) and memory (slave): valid/ready request
// channel plus valid/ready response channel carrying read data and a bus error flag.
interface lsu_mem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_wen;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [3:0]        mem_req_wstrb;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [DATA_W-1:0] mem_resp_rdata;
    logic              mem_resp_err;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );
endinterface

// File: rtl/lsu_mem_access.sv
// Single-outstanding load/store unit: IDLE->REQ->RESP->DONE, byte-lane store steering and
// load extension. Define LSU_MISALIGN_CHECK_EN to fault misaligned h/hu/w accesses locally.
module lsu_mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [2:0]          mem_op,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    lsu_mem_access_if.master    mem,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic                out_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t              state_q, state_d;
    logic                wen_q;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic                access;
    logic                op_ok;
    logic                misalign;
    logic                fault;
    logic [1:0]          off;
    logic [DATA_W-1:0]   shifted;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;
    logic [DATA_W-1:0]   load_ext;
    logic [DATA_W-1:0]   st_wdata;
    logic [3:0]          st_wstrb;

    assign access = rd_en | wr_en;
    // Stores take the bus write path whenever wr_en is set; rd_en only selects legal load ops.
    assign op_ok  = wr_en ? ~mem_op[2]
                          : (mem_op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = ((mem_op[1:0] == 2'b01) && addr[0]) ||
                      ((mem_op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault = access & (~op_ok | misalign);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = (!access || fault) ? DONE : REQ;
            REQ:  if (mem.mem_req_ready)  state_d = RESP;
            RESP: if (mem.mem_resp_valid) state_d = DONE;
            DONE: if (out_ready)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load path: halves select by off[1] only, so off=1/3 still read the aligned half.
    assign off     = addr_q[1:0];
    assign shifted = mem.mem_resp_rdata >> {off, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = off[1] ? mem.mem_resp_rdata[31:16] : mem.mem_resp_rdata[15:0];

    always_comb begin
        load_ext = mem.mem_resp_rdata;
        case (op_q)
            3'b000:  load_ext = {{(DATA_W-8){byte_v[7]}}, byte_v};
            3'b001:  load_ext = {{(DATA_W-16){half_v[15]}}, half_v};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}}, byte_v};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}}, half_v};
            default: load_ext = mem.mem_resp_rdata;
        endcase
    end

    // Store lanes: data is replicated so the strobe alone picks the target bytes.
    always_comb begin
        st_wdata = wdata_q;
        st_wstrb = 4'hF;
        case (op_q[1:0])
            2'b00: begin
                st_wdata = {4{wdata_q[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{wdata_q[15:0]}};
                st_wstrb = 4'b0011 << off;
            end
            default: begin
                st_wdata = wdata_q;
                st_wstrb = 4'hF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                wen_q   <= wr_en;
                op_q    <= mem_op;
                addr_q  <= addr;
                wdata_q <= wdata;
                rdata_q <= '0;
                err_q   <= fault;
            end
            if (state_q == RESP && mem.mem_resp_valid) begin
                err_q   <= mem.mem_resp_err;
                rdata_q <= (mem.mem_resp_err || wen_q) ? '0 : load_ext;
            end
        end
    end

    // Outputs are gated by state so everything but in_ready reads 0 outside its phase.
    assign in_ready           = (state_q == IDLE);
    assign mem.mem_req_valid  = (state_q == REQ);
    assign mem.mem_req_addr   = (state_q == REQ) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem.mem_req_wen    = (state_q == REQ) & wen_q;
    assign mem.mem_req_wdata  = (state_q == REQ && wen_q) ? st_wdata : '0;
    assign mem.mem_req_wstrb  = (state_q == REQ && wen_q) ? st_wstrb : 4'h0;
    assign mem.mem_resp_ready = (state_q == RESP);
    assign out_valid          = (state_q == DONE);
    assign out_rdata          = (state_q == DONE) ? rdata_q : '0;
    assign out_err            = (state_q == DONE) & err_q;
endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: vector table of single accesses plus hand sequences
// for bus/writeback back-pressure and reset in the middle of an access.
module tb_lsu_mem_access;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    lsu_mem_access_if #(.ADDR_W(32), .DATA_W(32)) mem ();

    lsu_mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .rd_en(rd_en), .wr_en(wr_en), .mem_op(mem_op), .addr(addr), .wdata(wdata),
        .mem(mem.master),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        rerr;
        logic        bus;
        logic [31:0] req_addr;
        logic [3:0]  wstrb;
        logic [31:0] req_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Zero-wait-state access: accept at N, request at N+1, response at N+2, result at N+3.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk({v.name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; rd_en = v.rd; wr_en = v.wr; mem_op = v.op;
        addr = v.addr; wdata = v.wdata;
        mem.mem_req_ready = 1'b1; mem.mem_resp_valid = 1'b1;
        mem.mem_resp_rdata = v.rdata; mem.mem_resp_err = v.rerr;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (v.bus) begin
            chk({v.name, " req_valid"}, {31'd0, mem.mem_req_valid}, 32'd1);
            chk({v.name, " req_addr"}, mem.mem_req_addr, v.req_addr);
            chk({v.name, " req_wen"}, {31'd0, mem.mem_req_wen}, {31'd0, v.wr});
            chk({v.name, " req_wstrb"}, {28'd0, mem.mem_req_wstrb}, {28'd0, v.wstrb});
            if (v.wr) chk({v.name, " req_wdata"}, mem.mem_req_wdata, v.req_wdata);
            @(negedge clk);
            chk({v.name, " resp_ready"}, {31'd0, mem.mem_resp_ready}, 32'd1);
            chk({v.name, " early out_valid"}, {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end else begin
            chk({v.name, " no req_valid"}, {31'd0, mem.mem_req_valid}, 32'd0);
        end
        chk({v.name, " out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({v.name, " out_rdata"}, out_rdata, v.exp_rdata);
        chk({v.name, " out_err"}, {31'd0, out_err}, {31'd0, v.exp_err});
        mem.mem_resp_valid = 1'b0; mem.mem_req_ready = 1'b0;
    endtask

    initial begin
        mem.mem_req_ready = 1'b0; mem.mem_resp_valid = 1'b0;
        mem.mem_resp_rdata = '0; mem.mem_resp_err = 1'b0;

        //          rd   wr   op      addr          wdata         rdata         err  bus  req_addr      strb     req_wdata     exp_rdata     e
        vecs.push_back('{1'b1,1'b0,3'b000,32'h8000_0003,32'h0,        32'h8012_3456,1'b0,1'b1,32'h8000_0000,4'b0000,32'h0,        32'hFFFF_FF80,1'b0,"lb_neg"});
        vecs.push_back('{1'b1,1'b0,3'b101,32'h8000_0002,32'h0,        32'hBEEF_1234,1'b0,1'b1,32'h8000_0000,4'b0000,32'h0,        32'h0000_BEEF,1'b0,"lhu_hi"});
        vecs.push_back('{1'b0,1'b1,3'b000,32'h8000_0001,32'h0000_00AB,32'h0,        1'b0,1'b1,32'h8000_0000,4'b0010,32'hABAB_ABAB,32'h0,        1'b0,"sb_off1"});
        vecs.push_back('{1'b1,1'b0,3'b001,32'h0000_0010,32'h0,        32'h1234_8765,1'b0,1'b1,32'h0000_0010,4'b0000,32'h0,        32'hFFFF_8765,1'b0,"lh_lo"});
        vecs.push_back('{1'b1,1'b0,3'b100,32'h0000_0012,32'h0,        32'hA1B2_C3D4,1'b0,1'b1,32'h0000_0010,4'b0000,32'h0,        32'h0000_00B2,1'b0,"lbu_off2"});
        vecs.push_back('{1'b1,1'b0,3'b000,32'h0000_0005,32'h0,        32'h0000_7F00,1'b0,1'b1,32'h0000_0004,4'b0000,32'h0,        32'h0000_007F,1'b0,"lb_pos"});
        vecs.push_back('{1'b1,1'b0,3'b010,32'h0000_0020,32'h0,        32'hDEAD_BEEF,1'b0,1'b1,32'h0000_0020,4'b0000,32'h0,        32'hDEAD_BEEF,1'b0,"lw"});
        vecs.push_back('{1'b0,1'b1,3'b001,32'h0000_0032,32'h1111_CAFE,32'h0,        1'b0,1'b1,32'h0000_0030,4'b1100,32'hCAFE_CAFE,32'h0,        1'b0,"sh_hi"});
        vecs.push_back('{1'b0,1'b1,3'b010,32'h0000_0040,32'h0123_4567,32'h0,        1'b0,1'b1,32'h0000_0040,4'b1111,32'h0123_4567,32'h0,        1'b0,"sw"});
        vecs.push_back('{1'b1,1'b0,3'b000,32'h0000_0050,32'h0,        32'h0000_00FF,1'b1,1'b1,32'h0000_0050,4'b0000,32'h0,        32'h0,        1'b1,"lb_buserr"});
        vecs.push_back('{1'b0,1'b0,3'b010,32'h0000_0060,32'h0,        32'h5555_5555,1'b0,1'b0,32'h0,        4'b0000,32'h0,        32'h0,        1'b0,"noop"});
        vecs.push_back('{1'b1,1'b0,3'b011,32'h0000_0070,32'h0,        32'h5555_5555,1'b0,1'b0,32'h0,        4'b0000,32'h0,        32'h0,        1'b1,"ld_badop"});
        vecs.push_back('{1'b0,1'b1,3'b100,32'h0000_0080,32'h1234_5678,32'h0,        1'b0,1'b0,32'h0,        4'b0000,32'h0,        32'h0,        1'b1,"st_badop"});
`ifdef LSU_MISALIGN_CHECK_EN
        vecs.push_back('{1'b1,1'b0,3'b010,32'h8000_0002,32'h0,        32'h1122_3344,1'b0,1'b0,32'h0,        4'b0000,32'h0,        32'h0,        1'b1,"lw_misal"});
        vecs.push_back('{1'b0,1'b1,3'b001,32'h0000_0007,32'h0000_BEEF,32'h0,        1'b0,1'b0,32'h0,        4'b0000,32'h0,        32'h0,        1'b1,"sh_misal"});
`else
        vecs.push_back('{1'b1,1'b0,3'b010,32'h8000_0002,32'h0,        32'h1122_3344,1'b0,1'b1,32'h8000_0000,4'b0000,32'h0,        32'h1122_3344,1'b0,"lw_misal"});
        vecs.push_back('{1'b0,1'b1,3'b001,32'h0000_0007,32'h0000_BEEF,32'h0,        1'b0,1'b1,32'h0000_0004,4'b1000,32'hBEEF_BEEF,32'h0,        1'b0,"sh_off3"});
`endif

        // Reset state
        #2;
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst req_valid", {31'd0, mem.mem_req_valid}, 32'd0);
        chk("rst resp_ready", {31'd0, mem.mem_resp_ready}, 32'd0);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_rdata", out_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Back-pressure: bus stalls 5 cycles, writeback stalls 3 cycles
        @(negedge clk);
        in_valid = 1'b1; rd_en = 1'b0; wr_en = 1'b1; mem_op = 3'b010;
        addr = 32'h0000_0100; wdata = 32'h5A5A_5A5A;
        mem.mem_req_ready = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        for (int c = 0; c < 5; c++) begin
            chk("stall req_valid", {31'd0, mem.mem_req_valid}, 32'd1);
            chk("stall req_addr", mem.mem_req_addr, 32'h0000_0100);
            chk("stall req_wdata", mem.mem_req_wdata, 32'h5A5A_5A5A);
            chk("stall req_wstrb", {28'd0, mem.mem_req_wstrb}, 32'hF);
            chk("stall in_ready", {31'd0, in_ready}, 32'd0);
            if (c == 4) mem.mem_req_ready = 1'b1;
            @(negedge clk);
        end
        mem.mem_req_ready = 1'b0;
        chk("stall resp_ready", {31'd0, mem.mem_resp_ready}, 32'd1);
        mem.mem_resp_valid = 1'b1; mem.mem_resp_rdata = 32'h0; mem.mem_resp_err = 1'b0;
        @(negedge clk);
        mem.mem_resp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("hold out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold out_err", {31'd0, out_err}, 32'd0);
            chk("hold in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release out_valid", {31'd0, out_valid}, 32'd0);
        chk("release in_ready", {31'd0, in_ready}, 32'd1);

        // Reset while waiting in RESP; a late response must be ignored
        in_valid = 1'b1; rd_en = 1'b1; wr_en = 1'b0; mem_op = 3'b010; addr = 32'h0000_0200;
        mem.mem_req_ready = 1'b1; mem.mem_resp_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre-rst resp_ready", {31'd0, mem.mem_resp_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst resp_ready", {31'd0, mem.mem_resp_ready}, 32'd0);
        chk("midrst req_valid", {31'd0, mem.mem_req_valid}, 32'd0);
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem.mem_req_ready = 1'b0;
        mem.mem_resp_valid = 1'b1; mem.mem_resp_rdata = 32'h0000_0BAD;
        @(negedge clk);
        chk("late resp out_valid", {31'd0, out_valid}, 32'd0);
        chk("late resp in_ready", {31'd0, in_ready}, 32'd1);
        chk("late resp req_valid", {31'd0, mem.mem_req_valid}, 32'd0);
        mem.mem_resp_valid = 1'b0;
        run_vec('{1'b1,1'b0,3'b010,32'h0000_0204,32'h0,32'h600D_F00D,1'b0,1'b1,32'h0000_0204,4'b0000,32'h0,32'h600D_F00D,1'b0,"lw_after_rst"});

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
